mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle signed multiply/divide engine directly downstream of the bus datapath.
- Operand A comes from register Y; operand B comes from the bus (muxBusOut).
- Drives C_out_HI / C_out_LO into the Z_HI / Z_LO registers.
- The control unit pulses start, waits for done, then asserts Zhighin/Zlowin.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH split into HI/LO.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request; sampled in IDLE or DONE.
- op  in  1  0 = multiply, 1 = divide.
- a_in  in  WIDTH  multiplicand / dividend (from Y).
- b_in  in  WIDTH  multiplier / divisor (from bus).
- busy  out  1  high in RUN and FIX.
- done  out  1  high for exactly one cycle, in DONE.
- div_by_zero  out  1  sticky flag for the last divide; cleared on next accepted start.
- C_out_HI  out  WIDTH  product[63:32] / remainder.
- C_out_LO  out  WIDTH  product[31:0] / quotient.

Behaviour:
- Reset (clr=0 at an edge):
  - state = IDLE; busy = done = div_by_zero = 0; C_out_HI = C_out_LO = 0; counter = 0.
  - Applies in any state, including mid-operation; partial results are discarded.
- States: IDLE, RUN, FIX, DONE.
- Operand capture:
  - At edge E0 with start=1 in IDLE or DONE: latch a_in, b_in, op; clear div_by_zero; go to RUN.
  - start while busy=1 is ignored.
- RUN: one iteration per edge, 32 iterations (E1..E32); counter counts 0..31; at count 31 go to FIX.
- Multiply: radix-2 Booth on a 65-bit {acc, multiplier, q-1} register.
  - Per step: add/subtract the sign-extended multiplicand per the {q0, q-1} pair, then arithmetic shift right by 1.
- Divide: non-restoring on magnitudes |a| and |b|; the partial remainder is 33 bits.
- FIX (edge E33):
  - Divide only: final remainder restore if negative.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a), i.e. truncation toward zero.
  - Register C_out_HI/C_out_LO; go to DONE.
- DONE (cycle after E33): done=1, busy=0.
  - At E34: go to IDLE, or RUN if start=1.
  - Outputs hold until the next FIX or reset.
- Latency: done is high in the 34th cycle after the start edge.
- Divide by zero (b_in = 0, op=1):
  - RUN is skipped; IDLE→FIX at E1, DONE at E2.
  - C_out_LO = 0xFFFFFFFF, C_out_HI = a_in, div_by_zero = 1.
- Overflow 0x80000000 / 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0; no flag.
- Multiply never overflows; the full 64-bit signed product is produced.
- All arithmetic is two's complement.
- No outputs are combinational from inputs; all are registered.

Decomposition:
- Package mul_div_pkg:
  - op encoding (OP_MUL = 0, OP_DIV = 1).
  - state enum (IDLE, RUN, FIX, DONE).
  - default WIDTH.
  - DIV0_QUOTIENT = 32'hFFFFFFFF.
- Sub-module mul_div_step (combinational): one Booth or non-restoring iteration.
  - Inputs: current working register, operand, op.
  - Output: next working register.
- The top level holds the FSM, counter, operand registers and output registers.

Test Plan:
- MUL 7 × −3 (a=0x00000007, b=0xFFFFFFFD) → done 34 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high cycles 1–33.
- MUL 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000.
- DIV −7 / 2 (a=0xFFFFFFF9, b=2) → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); DIV 100 / −7 → LO=0xFFFFFFF2, HI=0x00000002.
- DIV 5 / 0 → done 2 cycles after start; LO=0xFFFFFFFF, HI=5, div_by_zero=1; next MUL start clears div_by_zero.
- Start MUL 3×4, assert clr=0 at cycle 10 → next edge busy=0, done=0, outputs 0, state IDLE; no done pulse follows.
- Start held high through DONE after MUL 2×3 → LO=6 visible with done; second operation (DIV 9/3) runs immediately, done 34 cycles later with LO=3, HI=0; start pulses during busy are ignored.

Source files
------------

// File: rtl/mul_div_pkg.sv
// ============================================================================
// Module   : mul_div_pkg
// Purpose  : Shared types and constants for the signed multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_div_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/mul_div_step.sv
// ============================================================================
// Module   : mul_div_step
// Purpose  : One combinational Booth (multiply) or non-restoring (divide) step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_step
  import mul_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH:0] i_work,
  input  logic [WIDTH-1:0] i_operand,
  input  logic             i_op,
  output logic [2*WIDTH:0] o_workNext
);

  logic [WIDTH:0] w_acc;
  logic [WIDTH:0] w_mcand;
  logic [WIDTH:0] w_mulSum;
  logic [WIDTH:0] w_remShift;
  logic [WIDTH:0] w_divisor;
  logic [WIDTH:0] w_remNext;

  always_comb begin
    // Booth sum kept one bit wider so a -2^(W-1) multiplicand cannot overflow before the shift.
    w_acc   = {i_work[2*WIDTH], i_work[2*WIDTH:WIDTH+1]};
    w_mcand = {i_operand[WIDTH-1], i_operand};
    case (i_work[1:0])
      2'b01:   w_mulSum = w_acc + w_mcand;
      2'b10:   w_mulSum = w_acc - w_mcand;
      default: w_mulSum = w_acc;
    endcase

    w_remShift = {i_work[2*WIDTH-1:WIDTH], i_work[WIDTH-1]};
    w_divisor  = {1'b0, i_operand};
    w_remNext  = i_work[2*WIDTH] ? (w_remShift + w_divisor) : (w_remShift - w_divisor);

    if (i_op == OP_DIV) begin
      o_workNext = {w_remNext, i_work[WIDTH-2:0], ~w_remNext[WIDTH]};
    end else begin
      o_workNext = {w_mulSum, i_work[WIDTH:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Multi-cycle signed multiply/divide engine feeding Z_HI / Z_LO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] C_out_HI,
  output logic [WIDTH-1:0] C_out_LO
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH:0]   r_work;
  logic [WIDTH-1:0]   r_operand;
  logic               r_op;
  logic               r_aNeg;
  logic               r_bNeg;
  logic               r_div0;

  logic [2*WIDTH:0]   w_workNext;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;
  logic               w_startDiv0;
  logic [WIDTH:0]     w_rem;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_hiDiv;
  logic [WIDTH-1:0]   w_loDiv;

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .i_work     (r_work),
    .i_operand  (r_operand),
    .i_op       (r_op),
    .o_workNext (w_workNext)
  );

  always_comb begin
    w_aMag      = a_in[WIDTH-1] ? -a_in : a_in;
    w_bMag      = b_in[WIDTH-1] ? -b_in : b_in;
    w_startDiv0 = (op == OP_DIV) && (b_in == '0);
    // Final non-restoring correction, then re-apply signs (truncation toward zero).
    w_rem   = r_work[2*WIDTH:WIDTH] + (r_work[2*WIDTH] ? {1'b0, r_operand} : '0);
    w_quo   = r_work[WIDTH-1:0];
    w_hiDiv = r_aNeg ? -w_rem[WIDTH-1:0] : w_rem[WIDTH-1:0];
    w_loDiv = (r_aNeg ^ r_bNeg) ? -w_quo : w_quo;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_work      <= '0;
      r_operand   <= '0;
      r_op        <= 1'b0;
      r_aNeg      <= 1'b0;
      r_bNeg      <= 1'b0;
      r_div0      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      C_out_HI    <= '0;
      C_out_LO    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          r_state <= IDLE;
          if (start) begin
            r_op        <= op;
            r_aNeg      <= a_in[WIDTH-1];
            r_bNeg      <= b_in[WIDTH-1];
            r_div0      <= w_startDiv0;
            r_cnt       <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            if (op == OP_DIV) begin
              // A zero divisor keeps the raw dividend in the low half for the HI result.
              r_work    <= {{(WIDTH+1){1'b0}}, (w_startDiv0 ? a_in : w_aMag)};
              r_operand <= w_bMag;
            end else begin
              r_work    <= {{WIDTH{1'b0}}, b_in, 1'b0};
              r_operand <= a_in;
            end
            r_state <= w_startDiv0 ? FIX : RUN;
          end
        end
        RUN: begin
          r_work <= w_workNext;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            r_cnt   <= '0;
            r_state <= FIX;
          end
        end
        FIX: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= DONE;
          if (r_op == OP_MUL) begin
            C_out_HI <= r_work[2*WIDTH:WIDTH+1];
            C_out_LO <= r_work[WIDTH:1];
          end else if (r_div0) begin
            C_out_HI    <= r_work[WIDTH-1:0];
            C_out_LO    <= DIV0_QUOTIENT;
            div_by_zero <= 1'b1;
          end else begin
            C_out_HI <= w_hiDiv;
            C_out_LO <= w_loDiv;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Self-checking bench for mul_div_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] C_out_HI;
  logic [31:0] C_out_LO;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .C_out_HI    (C_out_HI),
    .C_out_LO    (C_out_LO)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Expected result straight from signed integer arithmetic.
  function automatic void computeExpected(input logic o, input logic [31:0] a, input logic [31:0] b,
                                          output logic [31:0] hi, output logic [31:0] lo,
                                          output logic dz);
    longint prod;
    int q;
    int r;
    dz = 1'b0;
    if (!o) begin
      prod = longint'($signed(a)) * longint'($signed(b));
      hi = prod[63:32];
      lo = prod[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
      dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      hi = 32'd0;
      lo = 32'h8000_0000;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      hi = r;
      lo = q;
    end
  endfunction

  // Cycle model: an accepted request completes after a fixed number of edges.
  bit          armed = 1'b0;
  bit          mBusy, mDone, mDiv0;
  logic [31:0] mHi, mLo, pHi, pLo, tHi, tLo;
  logic        pDz, tDz;
  int          mLeft;

  always @(posedge clk) begin
    if (!clr) begin
      armed <= 1'b1;
      mBusy <= 1'b0; mDone <= 1'b0; mDiv0 <= 1'b0;
      mHi <= '0; mLo <= '0; mLeft <= 0;
    end else if (mBusy) begin
      if (mLeft == 1) begin
        mBusy <= 1'b0; mDone <= 1'b1;
        mHi <= pHi; mLo <= pLo; mDiv0 <= pDz;
      end
      mLeft <= mLeft - 1;
    end else begin
      mDone <= 1'b0;
      if (start) begin
        computeExpected(op, a_in, b_in, tHi, tLo, tDz);
        pHi <= tHi; pLo <= tLo; pDz <= tDz;
        mBusy <= 1'b1;
        mDiv0 <= 1'b0;
        mLeft <= (op && b_in == 32'd0) ? 1 : 33;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy", {31'd0, busy}, {31'd0, mBusy});
      check("done", {31'd0, done}, {31'd0, mDone});
      check("div_by_zero", {31'd0, div_by_zero}, {31'd0, mDiv0});
      check("C_out_HI", C_out_HI, mHi);
      check("C_out_LO", C_out_LO, mLo);
    end
  end

  task automatic waitDone(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 100);
  endtask

  task automatic runOp(input string name, input logic o, input logic [31:0] a, input logic [31:0] b,
                       input bit lit, input int expLat, input logic [31:0] eHi,
                       input logic [31:0] eLo, input logic eDz);
    int k;
    @(posedge clk); #1;
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(k);
    check({name, " latency"}, k, expLat);
    if (lit) begin
      check({name, " HI"}, C_out_HI, eHi);
      check({name, " LO"}, C_out_LO, eLo);
      check({name, " dz"}, {31'd0, div_by_zero}, {31'd0, eDz});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit sawDone;
    clr = 1'b0; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset HI", C_out_HI, 32'd0);
    check("reset LO", C_out_LO, 32'd0);

    runOp("mul 7x-3", 1'b0, 32'h7, 32'hFFFF_FFFD, 1, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    runOp("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1, 34, 32'h4000_0000, 32'h0, 1'b0);
    runOp("mul -1x-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 34, 32'h0, 32'h1, 1'b0);
    runOp("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, 1, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    runOp("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 1, 34, 32'h2, 32'hFFFF_FFF2, 1'b0);
    runOp("div 5/0", 1'b1, 32'd5, 32'd0, 1, 2, 32'h5, 32'hFFFF_FFFF, 1'b1);
    runOp("mul 6x7", 1'b0, 32'd6, 32'd7, 1, 34, 32'h0, 32'd42, 1'b0);
    runOp("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 34, 32'h0, 32'h8000_0000, 1'b0);
    runOp("div max/min", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1, 34, 32'h7FFF_FFFF, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      runOp("rand", i[0], $urandom, $urandom, 0, 34, '0, '0, 1'b0);
    end

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; a_in = 32'd3; b_in = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 clr = 1'b0;
    @(posedge clk); #1 clr = 1'b1;
    check("clr busy", {31'd0, busy}, 32'd0);
    check("clr done", {31'd0, done}, 32'd0);
    check("clr HI", C_out_HI, 32'd0);
    check("clr LO", C_out_LO, 32'd0);
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    check("clr no done", {31'd0, sawDone}, 32'd0);

    // Start held through DONE chains a second operation.
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; a_in = 32'd2; b_in = 32'd3;
    @(posedge clk); #1;
    op = 1'b1; a_in = 32'd9; b_in = 32'd3;
    waitDone(k);
    check("held mul latency", k, 34);
    check("held mul LO", C_out_LO, 32'd6);
    check("held mul HI", C_out_HI, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 10) begin
        start = 1'b1; op = 1'b0; a_in = 32'd7; b_in = 32'd7;
      end else begin
        start = 1'b0;
      end
    end while (!done && k < 100);
    check("chained div latency", k, 34);
    check("chained div LO", C_out_LO, 32'd3);
    check("chained div HI", C_out_HI, 32'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
